urna_booth_arbiter: RTL

- Session controller and round-robin arbiter that shares one vote-tally datapath (the Urna counter block) between N_BOOTH voting booths.
- Sequences the election: idle → open → closed.
- Gates each booth with a poll-worker authorization, so each booth casts one vote per release.
- Forwards accepted vote codes to the tally over a valid/ready port.

---
 rtl/urna_pkg.sv | 27 ++
 rtl/urna_rr_pick.sv | 42 ++++
 rtl/urna_booth_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/urna_pkg.sv
`default_nettype none
// ============================================================================
// Module   : urna_pkg
// Brief    : Shared types and constants for the Urna booth arbiter: session
//            state encoding, default vote-code width and the two vote codes
//            the tally counts (every other code is a null vote).
// Revision : 1.0 - initial release
// ============================================================================
package urna_pkg;

  // Default width of a booth vote code (digit3..digit0)
  localparam int URNA_CODE_W = 4;

  // Session state, encoding is visible on the state_o port
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OPEN   = 2'b01,
    ST_COMMIT = 2'b10,
    ST_CLOSED = 2'b11
  } urna_state_e;

  // Vote codes recognised by the tally block
  localparam logic [URNA_CODE_W-1:0] CODE_C1 = 4'b0100;
  localparam logic [URNA_CODE_W-1:0] CODE_C2 = 4'b1000;

endpackage : urna_pkg
`default_nettype wire

// File: rtl/urna_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : urna_rr_pick
// Brief    : Combinational round-robin picker. Scans the eligible mask
//            starting just after the pointer, wrapping around, and returns
//            the first hit as a one-hot grant and as an index.
// Revision : 1.0 - initial release
// ============================================================================
module urna_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // First eligible booth at or after ptr+1, modulo N; the old owner is last
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 1; k <= N; k++) begin
      pos     = (int'(ptr_i) + k) % N;
      pos_idx = IDX_W'(pos);
      if (!found_o && elig_i[pos_idx]) begin
        found_o        = 1'b1;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
      end
    end
  end

endmodule : urna_rr_pick
`default_nettype wire

// File: rtl/urna_booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : urna_booth_arbiter
// Brief    : Election session controller (idle -> open -> closed) and
//            round-robin arbiter sharing one tally datapath between N_BOOTH
//            booths. A booth may cast one vote per poll-worker release; the
//            accepted vote is offered to the tally over valid/ready.
// Options  : URNA_ARB_TIMEOUT_EN - authorizations expire after TIMEOUT
//            cycles and report it on timeout_evt_o.
// Revision : 1.0 - initial release
// ============================================================================
module urna_booth_arbiter
  import urna_pkg::*;
#(
  parameter int N_BOOTH = 4,
  parameter int CODE_W  = URNA_CODE_W,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255,
  localparam int IDX_W  = (N_BOOTH > 1) ? $clog2(N_BOOTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        open_i,
  input  logic                        finish_i,
  input  logic [N_BOOTH-1:0]          release_i,
  input  logic [N_BOOTH-1:0]          req_i,
  input  logic [N_BOOTH*CODE_W-1:0]   code_i,
  output logic [N_BOOTH-1:0]          ack_o,
  output logic [N_BOOTH-1:0]          authorized_o,
  output logic                        tally_valid_o,
  output logic [CODE_W-1:0]           tally_code_o,
  input  logic                        tally_ready_i,
  output logic [IDX_W-1:0]            grant_id_o,
  output logic [1:0]                  state_o,
  output logic [CNT_W-1:0]            votes_total_o
`ifdef URNA_ARB_TIMEOUT_EN
  ,
  output logic [N_BOOTH-1:0]          timeout_evt_o
`endif
);

  urna_state_e          state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     grant_id_q;
  logic [CODE_W-1:0]    tally_code_q;
  logic                 tally_valid_q;
  logic                 finish_seen_q;
  logic [CNT_W-1:0]     votes_q;
  logic [N_BOOTH-1:0]   auth_q;
  logic [N_BOOTH-1:0]   auth_d;

  logic [N_BOOTH-1:0]   elig;
  logic [N_BOOTH-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [CODE_W-1:0]    pick_code;
  logic                 xfer;
  logic                 session_live;
  logic [N_BOOTH-1:0]   rel_ok;
  logic [N_BOOTH-1:0]   to_fire;

  // Releases only count while the session is running
  assign session_live = (state_q == ST_OPEN) || (state_q == ST_COMMIT);
  assign rel_ok       = session_live ? release_i : '0;
  assign elig         = req_i & auth_q;
  assign xfer         = (state_q == ST_COMMIT) && tally_valid_q && tally_ready_i;

  urna_rr_pick #(
    .N     (N_BOOTH),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_onehot),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // AND-OR mux of the granted booth's code using the one-hot grant
  always_comb begin
    pick_code = '0;
    for (int i = 0; i < N_BOOTH; i++) begin
      if (pick_onehot[i]) begin
        pick_code = pick_code | code_i[i*CODE_W +: CODE_W];
      end
    end
  end

  // Acknowledge the grantee during the cycle the tally takes the vote
  always_comb begin
    ack_o = '0;
    if (xfer) begin
      ack_o[grant_id_q] = 1'b1;
    end
  end

  // Authorization update: transfer and timeout clear, a release always wins
  always_comb begin
    auth_d = auth_q;
    if (xfer) begin
      auth_d[grant_id_q] = 1'b0;
    end
    auth_d = auth_d & ~to_fire;
    auth_d = auth_d | rel_ok;
  end

  // Authorization register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auth_q <= '0;
    end else begin
      auth_q <= auth_d;
    end
  end

`ifdef URNA_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [N_BOOTH-1:0] timeout_evt_q;

  for (genvar gi = 0; gi < N_BOOTH; gi++) begin : g_timeout
    logic [TO_W-1:0] cnt_q;
    logic            dec;

    // The grantee's clock is frozen while its vote is waiting on the tally
    assign dec = auth_q[gi] &&
                 !((state_q == ST_COMMIT) && (grant_id_q == IDX_W'(gi)));
    assign to_fire[gi] = dec && !rel_ok[gi] && (cnt_q <= TO_W'(1));

    // Per-booth lifetime counter, reloaded by every release
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (rel_ok[gi]) begin
        cnt_q <= TO_W'(TIMEOUT);
      end else if (dec && (cnt_q != '0)) begin
        cnt_q <= cnt_q - TO_W'(1);
      end
    end
  end

  // One-cycle expiry pulse per booth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_evt_q <= '0;
    end else begin
      timeout_evt_q <= to_fire;
    end
  end

  assign timeout_evt_o = timeout_evt_q;
`else
  logic unused_timeout_cfg;

  assign to_fire            = '0;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

  // Session FSM with the registered tally port, pointer and vote counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= IDX_W'(N_BOOTH - 1);
      grant_id_q    <= '0;
      tally_code_q  <= '0;
      tally_valid_q <= 1'b0;
      finish_seen_q <= 1'b0;
      votes_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (open_i) begin
            state_q <= ST_OPEN;
          end
        end
        ST_OPEN: begin
          tally_valid_q <= 1'b0;
          if (finish_i) begin
            state_q <= ST_CLOSED;
          end else if (pick_found) begin
            tally_code_q  <= pick_code;
            grant_id_q    <= pick_idx;
            tally_valid_q <= 1'b1;
            state_q       <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (finish_i) begin
            finish_seen_q <= 1'b1;
          end
          if (tally_ready_i) begin
            tally_valid_q <= 1'b0;
            ptr_q         <= grant_id_q;
            if (votes_q != {CNT_W{1'b1}}) begin
              votes_q <= votes_q + CNT_W'(1);
            end
            // A finish seen on this very edge still closes without reopening
            state_q <= (finish_seen_q || finish_i) ? ST_CLOSED : ST_OPEN;
          end
        end
        ST_CLOSED: begin
          tally_valid_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign authorized_o  = auth_q;
  assign tally_valid_o = tally_valid_q;
  assign tally_code_o  = tally_code_q;
  assign grant_id_o    = grant_id_q;
  assign state_o       = state_q;
  assign votes_total_o = votes_q;

endmodule : urna_booth_arbiter
`default_nettype wire
